// File: rtl/t03_mem_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// requester IDs and the default watchdog length.
package t03_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/t03_rr_picker.sv
// Combinational 2-way round-robin choice: a lone requester wins, a tie goes
// to the side that was not granted last.
module t03_rr_picker
   import t03_mem_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_valid,
   output logic o_grant
);

   always_comb begin
      o_valid = i_req0 | i_req1;
      o_grant = REQ_CPU;
      if (i_req0 && i_req1)
         o_grant = ~i_last_grant;
      else if (i_req1)
         o_grant = REQ_DMA;
   end

endmodule

// File: rtl/t03_mem_arbiter.sv
// Arbitrates the single memory bus between the CPU (0) and DMA (1) requesters,
// with a watchdog that aborts transactions the bus never acknowledges.
module t03_mem_arbiter
   import t03_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read0,
   input  logic              write0,
   input  logic [ADDR_W-1:0] address0,
   input  logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] dataOut0,
   output logic              ack0,
   output logic              err0,
   input  logic              read1,
   input  logic              write1,
   input  logic [ADDR_W-1:0] address1,
   input  logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] dataOut1,
   output logic              ack1,
   output logic              err1,
   output logic              busRead,
   output logic              busWrite,
   output logic [ADDR_W-1:0] busAddress,
   output logic [DATA_W-1:0] busData,
   input  logic [DATA_W-1:0] busDataOut,
   input  logic              busAck,
   output logic              grantId
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state, w_next;
   logic                r_last_grant, r_grant_id;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_bus_rd, r_bus_wr;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [DATA_W-1:0]   r_bus_data, r_dout0, r_dout1;
   logic                r_ack0, r_ack1, r_err0, r_err1;

   logic                w_valid, w_grant, w_rd, w_wr, w_timeout;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;

   t03_rr_picker u_picker (
      .i_req0       (read0 | write0),
      .i_req1       (read1 | write1),
      .i_last_grant (r_last_grant),
      .o_valid      (w_valid),
      .o_grant      (w_grant)
   );

   assign w_rd      = w_grant ? read1    : read0;
   assign w_wr      = w_grant ? write1   : write0;
   assign w_addr    = w_grant ? address1 : address0;
   assign w_data    = w_grant ? data1    : data0;
   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_valid) w_next = BUSY;
         BUSY:    if (busAck || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_cnt        <= '0;
         r_bus_rd     <= 1'b0;
         r_bus_wr     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_data   <= '0;
         r_dout0      <= '0;
         r_dout1      <= '0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
         case (r_state)
            IDLE: if (w_valid) begin
               r_grant_id   <= w_grant;
               r_last_grant <= w_grant;
               // write takes precedence when a requester raises both strobes
               r_bus_wr     <= w_wr;
               r_bus_rd     <= w_rd & ~w_wr;
               r_bus_addr   <= w_addr;
               r_bus_data   <= w_data;
               r_cnt        <= '0;
            end
            BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (busAck) begin
                  r_bus_rd <= 1'b0;
                  r_bus_wr <= 1'b0;
                  if (r_bus_rd) begin
                     if (r_grant_id) r_dout1 <= busDataOut;
                     else            r_dout0 <= busDataOut;
                  end
                  if (r_grant_id) r_ack1 <= 1'b1;
                  else            r_ack0 <= 1'b1;
               end else if (w_timeout) begin
                  r_bus_rd <= 1'b0;
                  r_bus_wr <= 1'b0;
                  if (r_grant_id) begin
                     r_dout1 <= '0;
                     r_ack1  <= 1'b1;
                     r_err1  <= 1'b1;
                  end else begin
                     r_dout0 <= '0;
                     r_ack0  <= 1'b1;
                     r_err0  <= 1'b1;
                  end
               end
            end
            DONE:    r_cnt <= '0;
            default: r_cnt <= '0;
         endcase
      end
   end

   assign busRead    = r_bus_rd;
   assign busWrite   = r_bus_wr;
   assign busAddress = r_bus_addr;
   assign busData    = r_bus_data;
   assign dataOut0   = r_dout0;
   assign dataOut1   = r_dout1;
   assign ack0       = r_ack0;
   assign ack1       = r_ack1;
   assign err0       = r_err0;
   assign err1       = r_err1;
   assign grantId    = r_grant_id;

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// Bench for t03_mem_arbiter: vector table of request pairs served through a
// scoreboard of expected bus transactions, plus a reset-mid-BUSY sequence.
module tb_t03_mem_arbiter;

   localparam int TO = 4;
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        read0, write0, read1, write1;
   logic [31:0] address0, data0, address1, data1;
   logic [31:0] dataOut0, dataOut1;
   logic        ack0, err0, ack1, err1;
   logic        busRead, busWrite, busAck, grantId;
   logic [31:0] busAddress, busData, busDataOut;

   always #5 clk = ~clk;

   t03_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .read0(read0), .write0(write0), .address0(address0), .data0(data0),
      .dataOut0(dataOut0), .ack0(ack0), .err0(err0),
      .read1(read1), .write1(write1), .address1(address1), .data1(data1),
      .dataOut1(dataOut1), .ack1(ack1), .err1(err1),
      .busRead(busRead), .busWrite(busWrite), .busAddress(busAddress),
      .busData(busData), .busDataOut(busDataOut), .busAck(busAck),
      .grantId(grantId)
   );

   typedef struct {
      logic        id;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;   // BUSY cycle carrying busAck; 0 = never acked
   } txn_t;

   // op = {read, write}
   typedef struct {
      logic [1:0]  op0, op1;
      logic [31:0] a0, d0, r0, a1, d1, r1;
      int          lat0, lat1;
      logic        first;  // required first grant on a tie
   } vec_t;

   txn_t        exp_q[$];
   logic [31:0] m_dout[2];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic id, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] r, input int lat);
      txn_t t;
      t.id = id; t.wr = op[0]; t.addr = a; t.wdata = d; t.rdata = r; t.lat = lat;
      exp_q.push_back(t);
   endtask

   task automatic serve_one();
      txn_t t;
      int   w, c, exp_busy;
      logic e;
      t = exp_q.pop_front();
      w = 0;
      do begin step(); w++; end while (!(busRead || busWrite) && w < 10);
      chk("grant_latency", w, 1);
      chk("grantId", grantId, t.id);
      chk("busWrite", busWrite, t.wr);
      chk("busRead", busRead, !t.wr);
      chk("busAddress", busAddress, t.addr);
      if (t.wr) chk("busData", busData, t.wdata);
      c = 0;
      while (c < 20) begin
         c++;
         if (c == t.lat) begin busAck = 1'b1; busDataOut = t.rdata; end
         step();
         busAck = 1'b0;
         busDataOut = JUNK;
         if (!(busRead || busWrite)) break;
      end
      e = (t.lat == 0 || t.lat > TO);
      exp_busy = e ? TO : t.lat;
      chk("busy_cycles", c, exp_busy);
      if (e)          m_dout[t.id] = 32'h0;
      else if (!t.wr) m_dout[t.id] = t.rdata;
      chk("ack_granted", t.id ? ack1 : ack0, 1'b1);
      chk("ack_other",   t.id ? ack0 : ack1, 1'b0);
      chk("err_granted", t.id ? err1 : err0, e);
      chk("err_other",   t.id ? err0 : err1, 1'b0);
      chk("dataOut0", dataOut0, m_dout[0]);
      chk("dataOut1", dataOut1, m_dout[1]);
      if (t.id) begin read1 = 1'b0; write1 = 1'b0; end
      else      begin read0 = 1'b0; write0 = 1'b0; end
      step();
      chk("ack_pulse_end", {28'h0, ack0, ack1, err0, err1}, 32'h0);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_strobes"}, {busRead, busWrite}, 0);
      chk({name, "_busAddress"}, busAddress, 0);
      chk({name, "_busData"}, busData, 0);
      chk({name, "_acks"}, {ack0, ack1, err0, err1}, 0);
      chk({name, "_dataOut0"}, dataOut0, 0);
      chk({name, "_dataOut1"}, dataOut1, 0);
      chk({name, "_grantId"}, grantId, 0);
   endtask

   vec_t vecs[9];

   initial begin
      //          op0    op1    a0      d0      r0            a1      d1     r1            lat0 lat1 first
      vecs[0] = '{2'b10, 2'b01, 32'h010, 32'h0, 32'h11111111, 32'h200, 32'h55, 32'h0,       1, 1, 1'b0};
      vecs[1] = '{2'b01, 2'b10, 32'h300, 32'hA5A5, 32'h0,     32'h400, 32'h0, 32'h22222222, 3, 2, 1'b0};
      vecs[2] = '{2'b10, 2'b00, 32'h100, 32'h0, 32'hCAFEF00D, 32'h0,  32'h0,  32'h0,        2, 0, 1'b0};
      vecs[3] = '{2'b10, 2'b10, 32'h500, 32'h0, 32'h33,       32'h600, 32'h0, 32'h44,       1, 1, 1'b1};
      vecs[4] = '{2'b11, 2'b00, 32'h700, 32'hDEAD, 32'h0,     32'h0,  32'h0,  32'h0,        1, 0, 1'b0};
      vecs[5] = '{2'b00, 2'b10, 32'h0,   32'h0, 32'h0,        32'h800, 32'h0, 32'h66,       0, 0, 1'b1};
      vecs[6] = '{2'b10, 2'b00, 32'h900, 32'h0, 32'h77,       32'h0,  32'h0,  32'h0,        1, 0, 1'b0};
      vecs[7] = '{2'b00, 2'b10, 32'h0,   32'h0, 32'h0,        32'hA00, 32'h0, 32'h88,       0, 4, 1'b1};
      vecs[8] = '{2'b01, 2'b00, 32'hB00, 32'h99, 32'h0,       32'h0,  32'h0,  32'h0,        0, 0, 1'b0};

      rst = 1'b1;
      read0 = 0; write0 = 0; read1 = 0; write1 = 0;
      address0 = 0; data0 = 0; address1 = 0; data1 = 0;
      busAck = 0; busDataOut = JUNK;
      m_dout[0] = 0; m_dout[1] = 0;
      step(); step();
      rst = 1'b0;
      check_all_zero("reset");

      // busAck while idle must not produce anything
      busAck = 1'b1;
      step();
      busAck = 1'b0;
      step();
      check_all_zero("idle_ack");

      foreach (vecs[i]) begin
         read0 = vecs[i].op0[1]; write0 = vecs[i].op0[0];
         address0 = vecs[i].a0;  data0 = vecs[i].d0;
         read1 = vecs[i].op1[1]; write1 = vecs[i].op1[0];
         address1 = vecs[i].a1;  data1 = vecs[i].d1;
         if (|vecs[i].op0 && |vecs[i].op1) begin
            if (vecs[i].first) begin
               push(1'b1, vecs[i].op1, vecs[i].a1, vecs[i].d1, vecs[i].r1, vecs[i].lat1);
               push(1'b0, vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].r0, vecs[i].lat0);
            end else begin
               push(1'b0, vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].r0, vecs[i].lat0);
               push(1'b1, vecs[i].op1, vecs[i].a1, vecs[i].d1, vecs[i].r1, vecs[i].lat1);
            end
         end else if (|vecs[i].op0) begin
            push(1'b0, vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].r0, vecs[i].lat0);
         end else begin
            push(1'b1, vecs[i].op1, vecs[i].a1, vecs[i].d1, vecs[i].r1, vecs[i].lat1);
         end
         while (exp_q.size() > 0) serve_one();
      end

      // reset during a write, followed by a stray ack
      write0 = 1'b1; address0 = 32'hC00; data0 = 32'h1234;
      step();
      chk("pre_reset_busWrite", busWrite, 1'b1);
      rst = 1'b1;
      write0 = 1'b0;
      step();
      rst = 1'b0;
      m_dout[0] = 0; m_dout[1] = 0;
      check_all_zero("mid_busy_reset");
      busAck = 1'b1; busDataOut = 32'h12345678;
      step();
      busAck = 1'b0; busDataOut = JUNK;
      step();
      check_all_zero("late_ack");

      // after reset a tie must go to the CPU first
      read0 = 1'b1; address0 = 32'hD00;
      read1 = 1'b1; address1 = 32'hE00;
      push(1'b0, 2'b10, 32'hD00, 32'h0, 32'hAAAA0000, 1);
      push(1'b1, 2'b10, 32'hE00, 32'h0, 32'hBBBB0000, 2);
      while (exp_q.size() > 0) serve_one();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
